// File: rtl/axis_pkt_gen_pkg.sv
// Shared definitions for the AXI-Stream packet generator.
//   state_t     : 2-bit FSM state encoding
//   LEN_W_DEF   : default width of length / count / beat counters
//   field layout: tdata = {pkt_seq[15:0], beat_idx[15:0]}
package axis_pkt_gen_pkg;

   localparam int LEN_W_DEF = 16;
   localparam int TDATA_W   = 32;
   localparam int FIELD_W   = 16;
   localparam int SEQ_LSB   = 16;
   localparam int IDX_LSB   = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND   = 2'd1,
      ST_GAP    = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   function automatic logic [TDATA_W-1:0] pack_tdata(input logic [FIELD_W-1:0] seq,
                                                     input logic [FIELD_W-1:0] idx);
      logic [TDATA_W-1:0] d;
      d = '0;
      d[SEQ_LSB +: FIELD_W] = seq;
      d[IDX_LSB +: FIELD_W] = idx;
      return d;
   endfunction

endpackage

// File: rtl/axis_beat_counter.sv
// Loadable down-counter with terminal-count flag.
//   aclk, areset : clock, asynchronous active-high reset
//   load/load_val: load has priority over decrement
//   dec          : decrement by one, saturating at zero
//   count, tc    : current value, tc = (count == 0)
module axis_beat_counter
#(
   parameter int W = 16
)
(
   input  logic         aclk,
   input  logic         areset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         tc
);

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator feeding one S2MM channel.
//   aclk, areset        : clock, asynchronous active-high reset
//   start, stop         : run request (IDLE only), sticky graceful halt
//   pkt_len, gap_len,
//   num_pkts            : run configuration, latched on start
//   busy, done, pkt_cnt : run status
//   m_axis_*            : master stream, tdata = {pkt_seq, beat_idx}
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for start, stream quiet
// ST_SEND   | tvalid high, beats of the current packet
// ST_GAP    | tvalid low for gap_len cycles between packets
// ST_FINISH | one cycle, done pulse, then back to IDLE
module axis_pkt_gen
   import axis_pkt_gen_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LEN_W  = LEN_W_DEF
)
(
   input  logic                aclk,
   input  logic                areset,
   input  logic                start,
   input  logic                stop,
   input  logic [LEN_W-1:0]    pkt_len,
   input  logic [7:0]          gap_len,
   input  logic [LEN_W-1:0]    num_pkts,
   output logic                busy,
   output logic                done,
   output logic [LEN_W-1:0]    pkt_cnt,
   output logic [DATA_W-1:0]   m_axis_tdata,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                m_axis_tlast,
   output logic [DATA_W/8-1:0] m_axis_tkeep
);

   state_t           state;
   logic [LEN_W-1:0] len_m1;
   logic [LEN_W-1:0] num_lat;
   logic [7:0]       gap_lat;
   logic [LEN_W-1:0] pkt_seq;
   logic             stop_req;

   logic [LEN_W-1:0] len_m1_in;
   logic [LEN_W-1:0] beat_cnt;
   logic [LEN_W-1:0] beat_idx;
   logic [LEN_W-1:0] beat_load_val;
   logic [7:0]       gap_cnt;
   logic             beat_tc;
   logic             gap_tc;
   logic             beat_load;
   logic             beat_dec;
   logic             gap_load;
   logic             gap_dec;
   logic             send;
   logic             xfer;
   logic             last_xfer;
   logic             run_done;

   // beat counter holds beats remaining after the current one; tc marks tlast
   assign len_m1_in     = (pkt_len == '0) ? '0 : pkt_len - LEN_W'(1);
   assign send          = (state == ST_SEND);
   assign xfer          = send & m_axis_tready;
   assign last_xfer     = xfer & beat_tc;
   assign beat_load     = ((state == ST_IDLE) & start) | last_xfer;
   assign beat_load_val = (state == ST_IDLE) ? len_m1_in : len_m1;
   assign beat_dec      = xfer & ~beat_tc;
   assign beat_idx      = len_m1 - beat_cnt;

   // gap counter loads gap-1 so GAP spans exactly gap_len cycles
   assign gap_load = last_xfer;
   assign gap_dec  = (state == ST_GAP) & ~gap_tc;

   // a stop arriving with the tlast transfer still ends the run there
   assign run_done = stop_req | stop |
                     ((num_lat != '0) && ((pkt_cnt + LEN_W'(1)) == num_lat));

   axis_beat_counter #(.W(LEN_W)) u_beat_ctr (
      .aclk     (aclk),
      .areset   (areset),
      .load     (beat_load),
      .load_val (beat_load_val),
      .dec      (beat_dec),
      .count    (beat_cnt),
      .tc       (beat_tc)
   );

   axis_beat_counter #(.W(8)) u_gap_ctr (
      .aclk     (aclk),
      .areset   (areset),
      .load     (gap_load),
      .load_val (gap_lat - 8'd1),
      .dec      (gap_dec),
      .count    (gap_cnt),
      .tc       (gap_tc)
   );

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state    <= ST_IDLE;
         len_m1   <= '0;
         num_lat  <= '0;
         gap_lat  <= '0;
         pkt_seq  <= '0;
         pkt_cnt  <= '0;
         stop_req <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  len_m1   <= len_m1_in;
                  gap_lat  <= gap_len;
                  num_lat  <= num_pkts;
                  pkt_cnt  <= '0;
                  pkt_seq  <= '0;
                  stop_req <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (stop) begin
                  stop_req <= 1'b1;
               end
               if (last_xfer) begin
                  pkt_cnt <= pkt_cnt + LEN_W'(1);
                  pkt_seq <= pkt_seq + LEN_W'(1);
                  if (run_done) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_FINISH;
                  end else if (gap_lat != 8'd0) begin
                     state <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (stop) begin
                  stop_req <= 1'b1;
               end
               if (gap_tc) begin
                  if (stop_req || stop) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_FINISH;
                  end else begin
                     state <= ST_SEND;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_axis_tvalid = send;
   assign m_axis_tlast  = send & beat_tc;
   assign m_axis_tdata  = send ? DATA_W'(pack_tdata(pkt_seq[FIELD_W-1:0], beat_idx[FIELD_W-1:0]))
                               : '0;
   assign m_axis_tkeep  = '1;

endmodule

// File: tb/tb_axis_pkt_gen.sv
module tb_axis_pkt_gen;

   logic        aclk;
   logic        areset;
   logic        start;
   logic        stop;
   logic [15:0] pkt_len;
   logic [7:0]  gap_len;
   logic [15:0] num_pkts;
   logic        busy;
   logic        done;
   logic [15:0] pkt_cnt;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic [3:0]  m_axis_tkeep;

   axis_pkt_gen #(.DATA_W(32), .LEN_W(16)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .start         (start),
      .stop          (stop),
      .pkt_len       (pkt_len),
      .gap_len       (gap_len),
      .num_pkts      (num_pkts),
      .busy          (busy),
      .done          (done),
      .pkt_cnt       (pkt_cnt),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tkeep  (m_axis_tkeep)
   );

   int total = 0;
   int bad   = 0;

   logic [32:0] exp_q[$];
   logic [32:0] exp_beat;
   int          rdy_mode = 0;
   bit          mon_en   = 0;
   int          exp_gap  = 0;
   int          cyc      = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          last_xfer_cyc = 0;
   bit          prev_stall = 0;
   logic [31:0] prev_data;
   logic        prev_last;
   bit          after_last = 0;
   int          low_run    = 0;

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      forever begin
         @(posedge aclk);
         cyc++;
      end
   end

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // stream monitor: scoreboard pop, hold-while-stalled, gap length, done pulses
   always @(negedge aclk) begin
      if (areset || !mon_en) begin
         prev_stall = 0;
         after_last = 0;
         low_run    = 0;
      end else begin
         if (prev_stall) begin
            total++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
               bad++;
               $display("FAIL hold: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                        m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
            end
         end
         if (!busy) begin
            after_last = 0;
            low_run    = 0;
         end else if (!m_axis_tvalid) begin
            low_run++;
         end else begin
            if (after_last) begin
               total++;
               if (low_run != exp_gap) begin
                  bad++;
                  $display("FAIL gap_len: got %0d idle cycles, need %0d", low_run, exp_gap);
               end
            end
            after_last = 0;
            low_run    = 0;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            last_xfer_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL extra_beat: got data=%h last=%b, need no beat", m_axis_tdata, m_axis_tlast);
            end else begin
               exp_beat = exp_q.pop_front();
               if (m_axis_tdata !== exp_beat[31:0] || m_axis_tlast !== exp_beat[32]) begin
                  bad++;
                  $display("FAIL beat: got data=%h last=%b, need data=%h last=%b",
                           m_axis_tdata, m_axis_tlast, exp_beat[31:0], exp_beat[32]);
               end
            end
            if (m_axis_tlast) after_last = 1;
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_last  = m_axis_tlast;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            total++;
            if (busy !== 1'b0) begin
               bad++;
               $display("FAIL busy_at_done: got %b, need 0", busy);
            end
         end
      end
   end

   task automatic push_run(input int len, input int npk);
      logic [15:0] pp;
      logic [15:0] bb;
      for (int p = 0; p < npk; p++) begin
         for (int b = 0; b < len; b++) begin
            pp = p[15:0];
            bb = b[15:0];
            exp_q.push_back({(b == len - 1), pp, bb});
         end
      end
   endtask

   task automatic do_start(input int len, input int gap, input int num);
      @(posedge aclk);
      #1;
      pkt_len  = len[15:0];
      gap_len  = gap[7:0];
      num_pkts = num[15:0];
      exp_gap  = gap;
      start    = 1'b1;
      @(posedge aclk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget, output bit ok);
      int n;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         @(posedge aclk);
         n++;
      end
      ok = (done_cnt != d0);
      repeat (3) @(posedge aclk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      total++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_stream: got valid=%b last=%b data=%h, need 0 0 0",
                  m_axis_tvalid, m_axis_tlast, m_axis_tdata);
      end
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || pkt_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_status: got busy=%b done=%b pkt_cnt=%0d, need 0 0 0", busy, done, pkt_cnt);
      end
      total++;
      if (m_axis_tkeep !== 4'hF) begin
         bad++;
         $display("FAIL tkeep: got %h, need f", m_axis_tkeep);
      end
      repeat (3) @(posedge aclk);
      #1;
      areset = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_back_to_back();
      int d0;
      bit ok;
      rdy_mode = 0;
      d0 = done_cnt;
      push_run(4, 2);
      do_start(4, 0, 2);
      total++;
      if (busy !== 1'b1 || m_axis_tvalid !== 1'b1) begin
         bad++;
         $display("FAIL b2b_busy_rise: got busy=%b valid=%b, need 1 1", busy, m_axis_tvalid);
      end
      wait_done(d0, 100, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL b2b_timeout: got no done, need done");
      end
      total++;
      if (done_cnt - d0 != 1 || pkt_cnt !== 16'd2 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL b2b_end: got dones=%0d pkt_cnt=%0d left=%0d, need 1 2 0",
                  done_cnt - d0, pkt_cnt, exp_q.size());
      end
   endtask

   task automatic test_gap_toggle();
      int d0;
      bit ok;
      rdy_mode = 1;
      d0 = done_cnt;
      push_run(3, 3);
      do_start(3, 5, 3);
      wait_done(d0, 300, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL gap_timeout: got no done, need done");
      end
      total++;
      if (done_cnt - d0 != 1 || pkt_cnt !== 16'd3 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL gap_end: got dones=%0d pkt_cnt=%0d left=%0d, need 1 3 0",
                  done_cnt - d0, pkt_cnt, exp_q.size());
      end
      rdy_mode = 0;
   endtask

   task automatic test_len_zero();
      int d0;
      bit ok;
      rdy_mode = 0;
      d0 = done_cnt;
      exp_q.push_back({1'b1, 32'h0000_0000});
      do_start(0, 0, 1);
      wait_done(d0, 50, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL len0_timeout: got no done, need done");
      end
      total++;
      if (done_cyc != last_xfer_cyc + 1) begin
         bad++;
         $display("FAIL len0_done_latency: got done at cycle %0d, need %0d", done_cyc, last_xfer_cyc + 1);
      end
      total++;
      if (pkt_cnt !== 16'd1 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL len0_end: got pkt_cnt=%0d left=%0d, need 1 0", pkt_cnt, exp_q.size());
      end
   endtask

   task automatic test_stop();
      int d0;
      bit ok;
      bit seen;
      rdy_mode = 0;
      d0 = done_cnt;
      push_run(8, 5);
      do_start(8, 2, 0);
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge aclk);
         if (m_axis_tvalid && m_axis_tdata == 32'h0004_0002) seen = 1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL stop_trigger: got no beat 00040002, need it");
      end
      stop = 1'b1;
      @(posedge aclk);
      #1;
      stop = 1'b0;
      wait_done(d0, 100, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL stop_timeout: got no done, need done");
      end
      repeat (10) @(posedge aclk);
      #1;
      total++;
      if (pkt_cnt !== 16'd5 || exp_q.size() != 0 || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL stop_end: got pkt_cnt=%0d left=%0d valid=%b busy=%b, need 5 0 0 0",
                  pkt_cnt, exp_q.size(), m_axis_tvalid, busy);
      end
   endtask

   task automatic test_stop_at_last();
      int d0;
      bit ok;
      bit seen;
      rdy_mode = 0;
      d0 = done_cnt;
      push_run(2, 2);
      do_start(2, 0, 0);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge aclk);
         if (m_axis_tvalid && m_axis_tready && m_axis_tdata == 32'h0001_0001) seen = 1;
      end
      stop = 1'b1;
      @(posedge aclk);
      #1;
      stop = 1'b0;
      wait_done(d0, 50, ok);
      total++;
      if (!seen || !ok) begin
         bad++;
         $display("FAIL stop_last_flow: got trigger=%b done=%b, need 1 1", seen, ok);
      end
      total++;
      if (pkt_cnt !== 16'd2 || exp_q.size() != 0 || done_cnt - d0 != 1) begin
         bad++;
         $display("FAIL stop_last_end: got pkt_cnt=%0d left=%0d dones=%0d, need 2 0 1",
                  pkt_cnt, exp_q.size(), done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid();
      int d0;
      bit ok;
      bit seen;
      rdy_mode = 0;
      push_run(6, 1);
      do_start(6, 0, 1);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge aclk);
         if (m_axis_tvalid && m_axis_tdata == 32'h0000_0003) seen = 1;
      end
      #2;
      areset = 1'b1;
      mon_en = 1'b0;
      #1;
      total++;
      if (!seen || m_axis_tvalid !== 1'b0 || busy !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'h0) begin
         bad++;
         $display("FAIL async_reset: got trigger=%b valid=%b busy=%b last=%b data=%h, need 1 0 0 0 0",
                  seen, m_axis_tvalid, busy, m_axis_tlast, m_axis_tdata);
      end
      exp_q.delete();
      repeat (2) @(posedge aclk);
      #1;
      areset = 1'b0;
      mon_en = 1'b1;
      d0 = done_cnt;
      push_run(2, 1);
      do_start(2, 0, 1);
      total++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0000_0000) begin
         bad++;
         $display("FAIL post_reset_first: got valid=%b data=%h, need 1 00000000", m_axis_tvalid, m_axis_tdata);
      end
      wait_done(d0, 50, ok);
      total++;
      if (!ok || pkt_cnt !== 16'd1 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL post_reset_end: got done=%b pkt_cnt=%0d left=%0d, need 1 1 0", ok, pkt_cnt, exp_q.size());
      end
   endtask

   task automatic test_start_while_busy();
      int d0;
      bit ok;
      bit seen;
      rdy_mode = 0;
      d0 = done_cnt;
      push_run(3, 2);
      do_start(3, 2, 2);
      @(posedge aclk);
      #1;
      pkt_len  = 16'd7;
      gap_len  = 8'd0;
      num_pkts = 16'd5;
      start    = 1'b1;
      @(posedge aclk);
      #1;
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge aclk);
         if (busy && !m_axis_tvalid) seen = 1;
      end
      @(posedge aclk);
      #1;
      start = 1'b1;
      @(posedge aclk);
      #1;
      start = 1'b0;
      wait_done(d0, 100, ok);
      total++;
      if (!seen || !ok) begin
         bad++;
         $display("FAIL busy_start_flow: got gap_seen=%b done=%b, need 1 1", seen, ok);
      end
      total++;
      if (pkt_cnt !== 16'd2 || exp_q.size() != 0 || done_cnt - d0 != 1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_start_end: got pkt_cnt=%0d left=%0d dones=%0d busy=%b, need 2 0 1 0",
                  pkt_cnt, exp_q.size(), done_cnt - d0, busy);
      end
   endtask

   task automatic test_random_ready();
      int d0;
      bit ok;
      rdy_mode = 2;
      d0 = done_cnt;
      push_run(5, 3);
      do_start(5, 1, 3);
      wait_done(d0, 400, ok);
      total++;
      if (!ok || pkt_cnt !== 16'd3 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL random_ready_end: got done=%b pkt_cnt=%0d left=%0d, need 1 3 0", ok, pkt_cnt, exp_q.size());
      end
      rdy_mode = 0;
   endtask

   initial begin
      areset   = 1'b1;
      start    = 1'b0;
      stop     = 1'b0;
      pkt_len  = 16'd0;
      gap_len  = 8'd0;
      num_pkts = 16'd0;
      test_reset();
      test_back_to_back();
      test_gap_toggle();
      test_len_zero();
      test_stop();
      test_stop_at_last();
      test_reset_mid();
      test_start_while_busy();
      test_random_ready();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_pkt_gen.md
AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 Parameter DATA_W, 32, width of stream data; fixed at 32 for the S2MM channels.
REQ-002 Parameter LEN_W, 16, width of the packet-length, packet-count and beat counters.
REQ-003 aclk  input  1  single clock; all logic rising-edge.
REQ-004 areset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle run request; sampled only in IDLE.
REQ-006 stop  input  1  graceful halt request; sampled every cycle while busy.
REQ-007 pkt_len  input  LEN_W  beats per packet; 0 is treated as 1.
REQ-008 gap_len  input  8  idle cycles between packets, with tvalid low.
REQ-009 num_pkts  input  LEN_W  packets per run; 0 means continuous.
REQ-010 busy  output  1  high from the accepted start until the run ends.
REQ-011 done  output  1  one-cycle pulse when a run ends.
REQ-012 pkt_cnt  output  LEN_W  packets completed in the current or last run.
REQ-013 m_axis_tdata  output  DATA_W  stream data toward S_AXIS_S2MM.
REQ-014 m_axis_tvalid  output  1  stream valid.
REQ-015 m_axis_tready  input  1  stream ready from the DMA.
REQ-016 m_axis_tlast  output  1  last beat of a packet.
REQ-017 m_axis_tkeep  output  DATA_W/8  constant all-ones.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, SEND, GAP and FINISH.
REQ-019 In IDLE, a start pulse SHALL latch pkt_len, gap_len and num_pkts, clear pkt_cnt and enter SEND on the next cycle; busy SHALL rise in that same cycle.
REQ-020 Inputs other than start SHALL be ignored in IDLE, and start SHALL be ignored outside IDLE.
REQ-021 In SEND, tvalid SHALL be 1 and tdata SHALL equal {pkt_seq[15:0], beat_idx[15:0]}, with both fields counting from 0.
REQ-022 Once asserted, tvalid, tdata and tlast SHALL hold stable until the beat is transferred (tvalid & tready).
REQ-023 beat_idx SHALL advance only on a transfer.
REQ-024 tlast SHALL be 1 exactly when beat_idx equals latched length-1.
REQ-025 On transfer of the tlast beat, pkt_cnt and pkt_seq SHALL increment and beat_idx SHALL clear.
REQ-026 After the tlast transfer, the next state SHALL be FINISH if the run is complete, otherwise GAP if gap_len > 0, otherwise SEND.
REQ-027 With a zero gap, packets SHALL be back-to-back, so tvalid stays high across the packet boundary.
REQ-028 In GAP, tvalid SHALL be 0 for exactly gap_len cycles, then the FSM SHALL enter SEND.
REQ-029 The run SHALL be complete when pkt_cnt reaches a non-zero num_pkts, or when a stop request is pending.
REQ-030 A stop request SHALL be latched (sticky) and SHALL never truncate a packet; the current packet always finishes with tlast.
REQ-031 A stop request received during GAP SHALL move the FSM to FINISH at the end of the gap without starting a new packet.
REQ-032 FINISH SHALL last one cycle: done = 1, busy = 0, then the FSM SHALL return to IDLE, and pkt_cnt SHALL hold its value.
REQ-033 pkt_seq and pkt_cnt SHALL wrap modulo 2^LEN_W.
REQ-034 Stop and the tlast transfer in the same cycle SHALL give one final packet only.
REQ-035 There SHALL be no combinational path from tready to any output.

Reset
REQ-036 areset SHALL asynchronously force IDLE, with tvalid = 0, tlast = 0, tdata = 0, busy = 0, done = 0, pkt_cnt = 0 and all counters and latches cleared.
REQ-037 Reset asserted mid-packet SHALL abandon the packet immediately; truncated output is acceptable because the DMA is reset from the same source.
REQ-038 Deassertion of areset is synchronized externally; the block SHALL need no start pulse in the first cycle after reset.

Structure
REQ-039 A shared package axis_pkt_gen_pkg SHALL hold the FSM state encoding (2-bit), the LEN_W default and the tdata field positions.
REQ-040 One sub-module, axis_beat_counter (a loadable counter with a terminal-count flag), SHALL be instantiated twice: once for beats and once for gap cycles.
REQ-041 Two instances of axis_pkt_gen SHALL feed the two S2MM channels independently.

Verification
REQ-042 Bench SHALL apply pkt_len=4, gap_len=0, num_pkts=2 with tready always 1, and check 8 consecutive beats 0x00000000..0x00000003, then 0x00010000..0x00010003; tlast on beats 4 and 8; one done pulse; pkt_cnt=2.
REQ-043 Bench SHALL apply pkt_len=3, gap_len=5 with tready toggling 1010..., and check tdata/tlast held while tready=0, exactly 5 tvalid-low cycles between packets, and no lost or duplicated beat.
REQ-044 Bench SHALL apply pkt_len=0, num_pkts=1, and check a single beat 0x00000000 with tlast=1 and done one cycle after the transfer.
REQ-045 Bench SHALL apply num_pkts=0 and pulse stop at beat 2 of packet 5 with pkt_len=8, and check packet 5 completes all 8 beats with tlast, no sixth packet starts, and pkt_cnt=5.
REQ-046 Bench SHALL assert areset mid-packet (beat 3 of 6), and check tvalid=0 and busy=0 asynchronously; a subsequent start gives tdata 0x00000000.
REQ-047 Bench SHALL pulse start while busy, and check it is ignored with no change to the latched pkt_len.
